// File: rtl/jtag_scan_master.sv
// JTAG initiator: runs one IR/DR scan per command and returns the captured TDO bits.
// Optional `define JTAG_RTI_PAD_EN appends RTI_CYCLES Run-Test/Idle TCK edges after each scan.
module jtag_scan_master #(
  parameter int DR_WIDTH   = 38,
  parameter int LEN_W      = 6,
  parameter int TCK_DIV    = 4,
  parameter int RTI_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_is_ir,
  input  logic [LEN_W-1:0]    i_cmd_len,
  input  logic [DR_WIDTH-1:0] i_cmd_data,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DR_WIDTH-1:0] o_rsp_data,
  output logic                o_tck,
  output logic                o_tms,
  output logic                o_tdi,
  input  logic                i_tdo,
  output logic                o_busy
);

  localparam int DIV_W = $clog2(TCK_DIV);
  localparam logic [LEN_W-1:0] LP_DRW = LEN_W'(DR_WIDTH);

  if (TCK_DIV < 2) begin : g_chk_div
    $error("jtag_scan_master: TCK_DIV must be 2 or more");
  end
  if ((2 ** LEN_W) <= DR_WIDTH) begin : g_chk_len
    $error("jtag_scan_master: LEN_W too narrow for DR_WIDTH");
  end
  if ((RTI_CYCLES < 1) || (RTI_CYCLES >= (2 ** LEN_W))) begin : g_chk_rti
    $error("jtag_scan_master: RTI_CYCLES out of range");
  end

`ifdef JTAG_RTI_PAD_EN
  typedef enum logic [2:0] {TLR_SEQ, IDLE, PRE, SHIFT, POST, RTI_PAD, RESP} state_t;
`else
  typedef enum logic [2:0] {TLR_SEQ, IDLE, PRE, SHIFT, POST, RESP} state_t;
`endif

  state_t              r_state, w_state_n, w_after;
  logic [LEN_W-1:0]    r_cnt, w_cnt_n;
  logic [DIV_W-1:0]    r_div;
  logic                r_tck, r_tms, r_tdi;
  logic [DR_WIDTH-1:0] r_data, r_rsp;
  logic [LEN_W-1:0]    r_len;
  logic                r_is_ir;
  logic                w_run, w_tc, w_rise, w_fall, w_accept, w_last;
  logic                w_tms_n, w_tdi_n;
  logic [LEN_W-1:0]    w_len_clamp;

  assign w_run       = !((r_state == IDLE) || (r_state == RESP));
  assign w_tc        = (r_div == DIV_W'(TCK_DIV - 1));
  assign w_rise      = w_run && w_tc && !r_tck;
  assign w_fall      = w_run && w_tc && r_tck;
  assign w_accept    = (r_state == IDLE) && i_cmd_valid;
  assign w_len_clamp = (i_cmd_len > LP_DRW) ? LP_DRW : i_cmd_len;

  // Each TAP state owns a fixed run of TCK periods; it advances on the falling edge.
  always_comb begin
    w_last  = 1'b0;
    w_after = r_state;
    case (r_state)
      TLR_SEQ: begin w_last = (r_cnt == LEN_W'(5));                        w_after = IDLE;  end
      PRE:     begin w_last = (r_cnt == (r_is_ir ? LEN_W'(3) : LEN_W'(2))); w_after = SHIFT; end
      SHIFT:   begin w_last = (r_cnt == (r_len - 1'b1));                   w_after = POST;  end
`ifdef JTAG_RTI_PAD_EN
      POST:    begin w_last = (r_cnt == LEN_W'(1));                        w_after = RTI_PAD; end
      RTI_PAD: begin w_last = (r_cnt == LEN_W'(RTI_CYCLES - 1));           w_after = RESP;  end
`else
      POST:    begin w_last = (r_cnt == LEN_W'(1));                        w_after = RESP;  end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_cnt_n   = '0;
          w_state_n = (i_cmd_len == '0) ? RESP : PRE;
        end
      end
      RESP: begin
        if (i_rsp_ready) w_state_n = IDLE;
      end
      default: begin
        if (w_fall) begin
          if (w_last) begin
            w_cnt_n   = '0;
            w_state_n = w_after;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // TMS/TDI for the edge about to be issued; PRE edge 0 is tms=1 for both scan types.
  always_comb begin
    w_tms_n = 1'b0;
    w_tdi_n = 1'b0;
    case (w_state_n)
      TLR_SEQ: w_tms_n = (w_cnt_n != LEN_W'(5));
      PRE:     w_tms_n = r_is_ir ? (w_cnt_n < LEN_W'(2)) : (w_cnt_n == '0);
      SHIFT: begin
        w_tms_n = (w_cnt_n == (r_len - 1'b1));
        w_tdi_n = r_data[w_cnt_n];
      end
      POST:    w_tms_n = (w_cnt_n == '0);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= TLR_SEQ;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div   <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_data  <= '0;
      r_len   <= '0;
      r_is_ir <= 1'b0;
      r_rsp   <= '0;
    end else begin
      if (w_run) begin
        if (w_tc) begin
          r_div <= '0;
          r_tck <= !r_tck;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end else begin
        r_div <= '0;
        r_tck <= 1'b0;
      end
      if (w_fall || w_accept) begin
        r_tms <= w_tms_n;
        r_tdi <= w_tdi_n;
      end
      if (w_rise && (r_state == SHIFT)) r_rsp[r_cnt] <= i_tdo;
      if (w_accept) begin
        r_data  <= i_cmd_data;
        r_len   <= w_len_clamp;
        r_is_ir <= i_cmd_is_ir;
        r_rsp   <= '0;
      end
    end
  end

  assign o_cmd_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_data  = r_rsp;
  assign o_busy      = w_run;
  assign o_tck       = r_tck;
  assign o_tms       = r_tms;
  assign o_tdi       = r_tdi;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: TAP edge logger, tdi->tdo loopback model and a response scoreboard.
module tb_jtag_scan_master;
  localparam int DRW = 38;
  localparam int LW  = 6;
  localparam int DIV = 4;
  localparam int RTI = 2;
`ifdef JTAG_RTI_PAD_EN
  localparam int PAD = RTI;
`else
  localparam int PAD = 0;
`endif
  localparam int PER = 2 * DIV;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_is_ir = 1'b0;
  logic [LW-1:0]  cmd_len = '0;
  logic [DRW-1:0] cmd_data = '0;
  logic           rsp_ready = 1'b0;
  logic           cmd_ready, rsp_valid, tck, tms, tdi, busy;
  logic [DRW-1:0] rsp_data;
  logic           tdo;
  logic           tdo_force = 1'b0;
  logic           m_cap = 1'b0;
  logic           m_tdo = 1'b0;

  jtag_scan_master #(.DR_WIDTH(DRW), .LEN_W(LW), .TCK_DIV(DIV), .RTI_CYCLES(RTI)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_is_ir(cmd_is_ir),
    .i_cmd_len(cmd_len), .i_cmd_data(cmd_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_tck(tck), .o_tms(tms), .o_tdi(tdi), .i_tdo(tdo), .o_busy(busy)
  );

  always #5 clk = ~clk;

  assign tdo = tdo_force ? 1'b1 : m_tdo;

  bit             tms_log[$];
  bit             tdi_log[$];
  bit             exp_tms[$];
  bit             exp_tdi[$];
  logic [DRW-1:0] exp_q[$];
  int             n_pass = 0;
  int             n_total = 0;
  int             clk_cnt = 0;
  int             edge_viol = 0;
  bit             rsp_seen = 1'b0;
  logic           prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;

  // TAP side: log each rising TCK; the loopback register shifts TDI out on the following fall.
  always @(posedge tck) begin
    m_cap <= tdi;
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
  end
  always @(negedge tck) m_tdo <= m_cap;

  always @(posedge clk) clk_cnt++;

  always @(negedge clk) begin
    if (!reset && prev_tck && tck && ((tms !== prev_tms) || (tdi !== prev_tdi))) edge_viol++;
    if (rsp_valid) rsp_seen = 1'b1;
    prev_tck = tck;
    prev_tms = tms;
    prev_tdi = tdi;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not reach summary");
    $fatal(1);
  end

  function automatic logic [DRW-1:0] low_mask(input int n);
    logic [DRW-1:0] m;
    m = '0;
    for (int i = 0; i < DRW; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // Expected TMS/TDI per rising TCK for a scan of n bits.
  task automatic build_exp(input bit ir, input int n, input logic [DRW-1:0] d);
    exp_tms.delete();
    exp_tdi.delete();
    exp_tms.push_back(1'b1);
    if (ir) exp_tms.push_back(1'b1);
    exp_tms.push_back(1'b0);
    exp_tms.push_back(1'b0);
    repeat (ir ? 4 : 3) exp_tdi.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      exp_tms.push_back(k == n - 1);
      exp_tdi.push_back(d[k]);
    end
    exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
    exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
    for (int k = 0; k < PAD; k++) begin
      exp_tms.push_back(1'b0);
      exp_tdi.push_back(1'b0);
    end
  endtask

  function automatic int log_diff();
    int e;
    e = 0;
    if (tms_log.size() != exp_tms.size() || tdi_log.size() != exp_tdi.size()) return 1000;
    for (int i = 0; i < tms_log.size(); i++)
      if (tms_log[i] != exp_tms[i] || tdi_log[i] != exp_tdi[i]) e++;
    return e;
  endfunction

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
  endtask

  task automatic issue(input bit ir, input logic [LW-1:0] len, input logic [DRW-1:0] d);
    int t;
    t = 0;
    while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_total++;
      $display("FAIL issue_timeout cmd_ready=%0b required=1", cmd_ready);
    end
    cmd_is_ir = ir; cmd_len = len; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output logic [DRW-1:0] data, output bit got);
    cyc = 0;
    while (!rsp_valid && cyc < 3000) begin @(negedge clk); cyc++; end
    got  = rsp_valid;
    data = rsp_data;
  endtask

  task automatic test_reset();
    int cyc;
    int e;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001)
      $display("FAIL reset_outputs tck/tms/tdi/rdy/vld/busy=%b required=010001",
               {tck, tms, tdi, cmd_ready, rsp_valid, busy});
    else n_pass++;
    n_total++;
    if (rsp_data !== '0) $display("FAIL reset_rsp_data got=%h required=0", rsp_data);
    else n_pass++;
    clear_logs();
    reset = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 1000) begin @(negedge clk); cyc++; end
    n_total++;
    if (cyc !== 6 * PER) $display("FAIL tlr_duration got=%0d required=%0d", cyc, 6 * PER);
    else n_pass++;
    e = (tms_log.size() == 6) ? 0 : 100;
    for (int i = 0; i < 6 && i < tms_log.size(); i++)
      if (tms_log[i] != (i < 5) || tdi_log[i] != 1'b0) e++;
    n_total++;
    if (e !== 0) $display("FAIL tlr_pattern errors=%0d edges=%0d required 6 edges tms=111110", e, tms_log.size());
    else n_pass++;
    repeat (20) @(negedge clk);
    n_total++;
    if (tck !== 1'b0 || tms_log.size() != 6 || busy !== 1'b0)
      $display("FAIL tlr_idle tck=%0b busy=%0b edges=%0d required tck=0 busy=0 edges=6", tck, busy, tms_log.size());
    else n_pass++;
  endtask

  task automatic test_dr_loopback();
    int cyc;
    bit got;
    logic [DRW-1:0] d, r, exp;
    d = 38'h2A_5A5A_A5A5;
    build_exp(1'b0, 38, d);
    exp_q.push_back((d << 1) & low_mask(38));
    clear_logs();
    edge_viol = 0;
    rsp_ready = 1'b0;
    issue(1'b0, 6'd38, d);
    wait_rsp(cyc, r, got);
    exp = exp_q.pop_front();
    n_total++;
    if (!got) $display("FAIL dr_rsp_timeout rsp_valid=0 required=1");
    else n_pass++;
    n_total++;
    if (r !== exp) $display("FAIL dr_loopback_data got=%h required=%h", r, exp);
    else n_pass++;
    n_total++;
    if (cyc !== PER * (38 + 5 + PAD)) $display("FAIL dr_duration got=%0d required=%0d", cyc, PER * (38 + 5 + PAD));
    else n_pass++;
    n_total++;
    if (log_diff() !== 0) $display("FAIL dr_tap_sequence errors=%0d edges=%0d required=%0d", log_diff(), tms_log.size(), exp_tms.size());
    else n_pass++;
    repeat (10) @(negedge clk);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp || tck !== 1'b0)
      $display("FAIL dr_rsp_hold vld=%0b data=%h tck=%0b required vld=1 data=%h tck=0", rsp_valid, rsp_data, tck, exp);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b0 || edge_viol !== 0)
      $display("FAIL dr_rsp_release vld=%0b viol=%0d required vld=0 viol=0", rsp_valid, edge_viol);
    else n_pass++;
  endtask

  task automatic test_ir_scan();
    int cyc;
    bit got;
    logic [DRW-1:0] r, exp;
    tdo_force = 1'b1;
    rsp_ready = 1'b1;
    build_exp(1'b1, 2, 38'h2);
    exp_q.push_back(38'h3);
    clear_logs();
    issue(1'b1, 6'd2, 38'h2);
    wait_rsp(cyc, r, got);
    exp = exp_q.pop_front();
    n_total++;
    if (!got || r !== exp) $display("FAIL ir_data got=%h valid=%0b required=%h", r, got, exp);
    else n_pass++;
    n_total++;
    if (cyc !== PER * (2 + 6 + PAD)) $display("FAIL ir_duration got=%0d required=%0d", cyc, PER * (2 + 6 + PAD));
    else n_pass++;
    n_total++;
    if (log_diff() !== 0) $display("FAIL ir_tap_sequence errors=%0d edges=%0d required=%0d", log_diff(), tms_log.size(), exp_tms.size());
    else n_pass++;
    @(negedge clk);
    rsp_ready = 1'b0;
    tdo_force = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL ir_ready_early vld=%0b rdy=%0b required vld=0 rdy=1", rsp_valid, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    int cyc;
    bit got;
    logic [DRW-1:0] r;
    exp_q.push_back('0);
    clear_logs();
    rsp_ready = 1'b1;
    issue(1'b0, 6'd0, DRW'({$urandom(), $urandom()}));
    wait_rsp(cyc, r, got);
    n_total++;
    if (!got || cyc > 2) $display("FAIL len0_latency got=%0d valid=%0b required<=2", cyc, got);
    else n_pass++;
    n_total++;
    if (r !== exp_q.pop_front()) $display("FAIL len0_data got=%h required=0", r);
    else n_pass++;
    repeat (10) @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if (tms_log.size() !== 0) $display("FAIL len0_no_tck edges=%0d required=0", tms_log.size());
    else n_pass++;
  endtask

  task automatic test_len_clamp();
    int cyc;
    bit got;
    logic [DRW-1:0] d, r, exp;
    d = DRW'({$urandom(), $urandom()});
    build_exp(1'b0, 38, d);
    exp_q.push_back((d << 1) & low_mask(38));
    clear_logs();
    rsp_ready = 1'b1;
    issue(1'b0, 6'd50, d);
    wait_rsp(cyc, r, got);
    exp = exp_q.pop_front();
    @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if (!got || r !== exp) $display("FAIL clamp_data got=%h required=%h", r, exp);
    else n_pass++;
    n_total++;
    if (cyc !== PER * (38 + 5 + PAD)) $display("FAIL clamp_duration got=%0d required=%0d", cyc, PER * (38 + 5 + PAD));
    else n_pass++;
    n_total++;
    if (log_diff() !== 0) $display("FAIL clamp_tap_sequence errors=%0d edges=%0d required=%0d", log_diff(), tms_log.size(), exp_tms.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    bit got;
    logic [DRW-1:0] d, r, exp;
    d = DRW'({$urandom(), $urandom()});
    exp_q.push_back((d << 1) & low_mask(16));
    rsp_ready = 1'b0;
    issue(1'b0, 6'd16, d);
    wait_rsp(cyc, r, got);
    exp = exp_q.pop_front();
    n_total++;
    if (!got || r !== exp) $display("FAIL bp_data got=%h required=%h", r, exp);
    else n_pass++;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL bp_hold unstable_cycles=%0d required=0", bad);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL bp_release vld=%0b rdy=%0b required vld=0 rdy=1", rsp_valid, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int cyc, t0, t, n_edges;
    bit got;
    logic [DRW-1:0] d, r, exp;
    d = DRW'({$urandom(), $urandom()});
    exp_q.push_back((d << 1) & low_mask(8));
    clear_logs();
    rsp_ready = 1'b1;
    issue(1'b0, 6'd8, d);
    t0 = clk_cnt;
    t = 0;
    while (tms_log.size() < 5 && t < 500) begin @(negedge clk); t++; end
    cmd_is_ir = 1'b1; cmd_len = 6'd20; cmd_data = ~d; cmd_valid = 1'b1;
    repeat (30) @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(cyc, r, got);
    t = clk_cnt - t0;
    exp = exp_q.pop_front();
    n_total++;
    if (!got || r !== exp) $display("FAIL busy_data got=%h required=%h", r, exp);
    else n_pass++;
    n_total++;
    if (t !== PER * (8 + 5 + PAD)) $display("FAIL busy_duration got=%0d required=%0d", t, PER * (8 + 5 + PAD));
    else n_pass++;
    @(negedge clk);
    rsp_seen = 1'b0;
    n_edges = tms_log.size();
    repeat (300) @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if (n_edges !== 8 + 5 + PAD || tms_log.size() != n_edges || rsp_seen)
      $display("FAIL busy_no_second_scan edges=%0d later=%0d rsp=%0b required edges=%0d rsp=0",
               n_edges, tms_log.size(), rsp_seen, 8 + 5 + PAD);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int t, cyc, e;
    logic [DRW-1:0] d;
    d = DRW'({$urandom(), $urandom()});
    exp_q.push_back((d << 1) & low_mask(20));
    clear_logs();
    rsp_ready = 1'b0;
    issue(1'b0, 6'd20, d);
    t = 0;
    while (tms_log.size() < 14 && t < 1000) begin @(negedge clk); t++; end
    reset = 1'b1;
    #1;
    n_total++;
    if ({tck, tms, rsp_valid, cmd_ready, busy} !== 5'b01001 || tms_log.size() != 14)
      $display("FAIL midreset_outputs tck/tms/vld/rdy/busy=%b edges=%0d required=01001 edges=14",
               {tck, tms, rsp_valid, cmd_ready, busy}, tms_log.size());
    else n_pass++;
    exp_q.delete();
    clear_logs();
    rsp_seen = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 1000) begin @(negedge clk); cyc++; end
    n_total++;
    if (cyc !== 6 * PER) $display("FAIL midreset_tlr_duration got=%0d required=%0d", cyc, 6 * PER);
    else n_pass++;
    e = (tms_log.size() == 6) ? 0 : 100;
    for (int i = 0; i < 6 && i < tms_log.size(); i++) if (tms_log[i] != (i < 5)) e++;
    n_total++;
    if (e !== 0) $display("FAIL midreset_tlr_pattern errors=%0d edges=%0d required tms=111110", e, tms_log.size());
    else n_pass++;
    repeat (50) @(negedge clk);
    n_total++;
    if (rsp_seen || rsp_valid !== 1'b0) $display("FAIL midreset_rsp_discarded seen=%0b required=0", rsp_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_dr_loopback();
    test_ir_scan();
    test_len_zero();
    test_len_clamp();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG initiator that drives TCK/TMS/TDI into a TAP and samples TDO, from the system clock.
- Executes one IR or DR scan per command, up to DR_WIDTH bits, and returns the captured TDO bits.
- Used to drive the CPU debug slave's virtual-JTAG scan chain in simulation and on-chip self-test, in place of the external USB-Blaster.

Parameters:
- DR_WIDTH, 38: maximum scan length in bits; width of cmd_data and rsp_data.
- LEN_W, 6: width of cmd_len; must satisfy 2^LEN_W > DR_WIDTH.
- TCK_DIV, 4: clk cycles per TCK half-period; legal range is 2 or more.
- RTI_CYCLES, 2: extra Run-Test/Idle TCK cycles appended per scan; applies only with JTAG_RTI_PAD_EN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: block idle and able to accept a command.
- cmd_is_ir, in, 1: 1 = IR scan, 0 = DR scan.
- cmd_len, in, LEN_W: number of bits to shift.
- cmd_data, in, DR_WIDTH: TDI bits, LSB shifted first.
- rsp_valid, out, 1: captured data available.
- rsp_ready, in, 1: response consumed.
- rsp_data, out, DR_WIDTH: captured TDO bits; bit i is the i-th bit shifted out.
- tck, out, 1: JTAG clock.
- tms, out, 1: JTAG mode select.
- tdi, out, 1: JTAG data in.
- tdo, in, 1: JTAG data out, synchronous to tck.
- busy, out, 1: scan or TAP reset sequence in progress.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1, divider=0.
- TCK generation:
  - The divider counts 0..TCK_DIV-1; tck toggles on the terminal count.
  - tms and tdi change only in the clk cycle where tck falls.
  - tdo is sampled in the clk cycle where tck rises.
  - tck idles low whenever no TAP movement is pending.
- FSM states: TLR_SEQ, IDLE, PRE, SHIFT, POST, RTI_PAD, RESP.
- TLR_SEQ:
  - Entered after reset release.
  - Drives 5 TCK rising edges with tms=1, then 1 with tms=0, so the TAP reaches Run-Test/Idle.
  - Then goes to IDLE.
- IDLE:
  - cmd_ready=1 and busy=0.
  - A command is accepted on the clk edge where cmd_valid and cmd_ready are both 1.
  - On acceptance: cmd_data is latched, the length is latched as min(cmd_len, DR_WIDTH), and cmd_ready drops on the next cycle.
  - cmd_len=0: no TCK activity; go straight to RESP with rsp_data=0.
- PRE: TMS walk into Shift, one value per TCK edge.
  - DR scan: tms = 1, 0, 0 (3 edges).
  - IR scan: tms = 1, 1, 0, 0 (4 edges).
- SHIFT:
  - N TCK edges; tdi = latched bit k on edge k.
  - tms=0 for edges 0..N-2 and tms=1 on edge N-1, which moves the TAP to Exit1.
  - tdo sampled on edge k is stored to rsp_data[k]; bits N..DR_WIDTH-1 are 0.
- POST: tms = 1, 0 (2 edges: Update, then Run-Test/Idle); tdi=0.
- RESP:
  - rsp_valid=1 and rsp_data is held stable until a clk edge with rsp_ready=1.
  - rsp_valid clears on that edge; the next state is IDLE.
  - rsp_ready may already be high when rsp_valid rises.
  - cmd_ready stays 0 for the whole of RESP, so only one command is outstanding at a time.
- Scan duration: DR scan = N+5 TCK periods; IR scan = N+6 TCK periods. One TCK period = 2*TCK_DIV clk cycles.
- cmd_valid while busy: ignored; it is not queued.
- Reset mid-scan:
  - Outputs return to their reset values immediately (asynchronously).
  - Any pending response is discarded.
  - TLR_SEQ reruns after reset release.

Optional Feature:
- Macro: JTAG_RTI_PAD_EN.
- Defined: after POST, the FSM enters RTI_PAD and issues RTI_CYCLES TCK edges with tms=0, tdi=0, then goes to RESP. Scan duration grows by RTI_CYCLES TCK periods. This gives the debug slave's sysclk synchroniser time to act on the update.
- Undefined: the RTI_PAD state does not exist, RTI_CYCLES is ignored, and POST goes directly to RESP.

Test Plan:
- Reset and TLR: release reset, TCK_DIV=4 -> exactly 6 tck rising edges with tms pattern 1,1,1,1,1,0; cmd_ready=1 after 48 clk cycles; tck remains low afterwards.
- DR scan loopback: tdo tied to a 1-cycle tck-delayed tdi (model register), DR scan len=38, data=0x2A_5A5A_A5A5 -> 43 TCK edges with tms 1,0,0,(0x37),1,1,0; rsp_data = captured model contents; rsp_valid held until rsp_ready.
- IR scan: cmd_is_ir=1, len=2, data=2'b10, tdo tied to 1 -> tms 1,1,0,0,0,1,1,0 (8 edges); tdi bits 0 then 1 on the shift edges; rsp_data=0x3.
- Boundaries:
  - len=0 -> no tck edge, and rsp_valid=1 with rsp_data=0 within 2 clk cycles.
  - len=50 -> clamped to 38 shift edges.
- Back-pressure and illegal issue:
  - Hold rsp_ready=0 for 100 cycles -> rsp_valid and rsp_data stable, cmd_ready=0.
  - Assert cmd_valid during SHIFT -> no second scan.
- Reset mid-SHIFT: assert reset at shift edge 10 -> tck=0, tms=1, rsp_valid=0 immediately; after release the 6-edge TLR sequence repeats; with JTAG_RTI_PAD_EN, RTI_CYCLES=2, a DR scan of len 8 takes 15 TCK periods.
